// File: rtl/connection_block_cfg_pkg.sv
// Shared definitions for the connection block: FSM state encoding and the
// elaboration-time helpers that derive select width, chain length and the
// shift-counter width from the channel geometry.
package connection_block_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,  // nothing shifted since the last update/reset
        StShift = 2'd1,  // 0 < count < CFG_BITS
        StFull  = 2'd2,  // count == CFG_BITS, the only state that may commit
        StOver  = 2'd3   // count > CFG_BITS, held until update or reset
    } cb_state_e;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned cb_clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Number of candidate taps feeding each output mux.
    function automatic int unsigned cb_num_cand(input int unsigned width,
                                                input int unsigned num_outs);
        return (2 * width) / num_outs;
    endfunction

    function automatic int unsigned cb_sel_w(input int unsigned width,
                                             input int unsigned num_outs);
        return cb_clog2(cb_num_cand(width, num_outs));
    endfunction

    function automatic int unsigned cb_cfg_bits(input int unsigned width,
                                                input int unsigned num_outs);
        return num_outs * cb_sel_w(width, num_outs);
    endfunction

    // Counter must hold CFG_BITS+1 so "over-shifted" is distinguishable.
    function automatic int unsigned cb_cnt_w(input int unsigned cfg_bits);
        return cb_clog2(cfg_bits + 2);
    endfunction

endpackage

// File: rtl/connection_block_cfg_track_mux.sv
// cb_track_mux: one output pin's track selector.
// Candidate m taps track index j = Index + NumOuts*(m>>1); even m take the
// leftward track (tracks_0_i[j]), odd m the rightward track (tracks_1_i[j]).
// Ports:
//   tracks_0_i  leftward channel tracks
//   tracks_1_i  rightward channel tracks
//   sel_i       candidate select
//   y_o         selected track value
module cb_track_mux #(
    parameter int unsigned ChannelWidth = 8,
    parameter int unsigned NumOuts      = 4,
    parameter int unsigned Index        = 0,
    parameter int unsigned SelW         = 2
) (
    input  logic [ChannelWidth-1:0] tracks_0_i,
    input  logic [ChannelWidth-1:0] tracks_1_i,
    input  logic [SelW-1:0]         sel_i,
    output logic                    y_o
);
    localparam int unsigned NumCand = 1 << SelW;
    localparam int unsigned TrkIdxW = (ChannelWidth > 1) ? $clog2(ChannelWidth) : 1;

    logic [NumCand-1:0] cand;

    always_comb begin
        logic [SelW-1:0]    m_idx;
        logic [TrkIdxW-1:0] j;
        cand = '0;
        for (int unsigned m = 0; m < NumCand; m++) begin
            m_idx = SelW'(m);
            j     = TrkIdxW'(Index + NumOuts * (m >> 1));
            cand[m_idx] = m_idx[0] ? tracks_1_i[j] : tracks_0_i[j];
        end
    end

    assign y_o = cand[sel_i];

endmodule

// File: rtl/connection_block_cfg.sv
// connection_block_cfg: drives NUM_OUTS pin inputs from a bidirectional
// routing channel through per-pin track muxes. Configuration is scanned into
// a shadow register and only copied to the active register by a cfg_update
// that arrives after exactly CFG_BITS shifts, so a half-loaded chain never
// disturbs the fabric.
// Ports:
//   scan_clk    sole clock
//   scan_rst_n  asynchronous active-low reset
//   tracks_0    leftward tracks
//   tracks_1    rightward tracks
//   scan_in     serial configuration data (first bit ends up in the MSB)
//   scan_en     shift enable
//   cfg_update  single-cycle commit request
//   scan_out    chain continuation, shadow MSB
//   out         pin drives, zero until a configuration has been committed
//   cfg_valid   an active configuration is loaded
//   cfg_err     sticky flag: last update was rejected
module connection_block_cfg
    import connection_block_cfg_pkg::*;
#(
    parameter int unsigned CHANNEL_ONEWAY_WIDTH = 8,
    parameter int unsigned NUM_OUTS             = 4,
    parameter int unsigned REG_OUT              = 0
) (
    input  logic                            scan_clk,
    input  logic                            scan_rst_n,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_0,
    input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_1,
    input  logic                            scan_in,
    input  logic                            scan_en,
    input  logic                            cfg_update,
    output logic                            scan_out,
    output logic [NUM_OUTS-1:0]             out,
    output logic                            cfg_valid,
    output logic                            cfg_err
);
    localparam int unsigned SEL_W    = cb_sel_w(CHANNEL_ONEWAY_WIDTH, NUM_OUTS);
    localparam int unsigned CFG_BITS = cb_cfg_bits(CHANNEL_ONEWAY_WIDTH, NUM_OUTS);
    localparam int unsigned CNT_W    = cb_cnt_w(CFG_BITS);
    localparam int unsigned NUM_CAND = cb_num_cand(CHANNEL_ONEWAY_WIDTH, NUM_OUTS);

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CntSat  = CNT_W'(CFG_BITS + 1);

    // Geometry checks at elaboration.
    if ((CHANNEL_ONEWAY_WIDTH % NUM_OUTS) != 0) begin : gen_bad_div
        $error("CHANNEL_ONEWAY_WIDTH must be divisible by NUM_OUTS");
    end
    if (NUM_CAND != (1 << SEL_W)) begin : gen_bad_pow2
        $error("candidate count per output must be a power of two");
    end

    cb_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CFG_BITS-1:0]  shadow_q, shadow_d;
    logic [CFG_BITS-1:0]  active_q, active_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 commit;

    // State register.
    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Next-state: shifting wins over update, so an update that coincides with
    // a shift never clears the counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (scan_en) begin
            // Cast drops the old MSB; also correct for a 1-bit chain.
            shadow_d = CFG_BITS'({shadow_q, scan_in});
            if (cnt_q != CntSat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == CntFull) begin
                state_d = StFull;
            end else if (cnt_d > CntFull) begin
                state_d = StOver;
            end else begin
                state_d = StShift;
            end
        end else if (cfg_update) begin
            cnt_d   = '0;
            state_d = StIdle;
        end
    end

    // Outputs of the FSM: commit decision and the configuration flags.
    always_comb begin
        commit   = cfg_update && !scan_en && (state_q == StFull);
        active_d = commit ? shadow_q : active_q;
        valid_d  = valid_q | commit;
        err_d    = cfg_update ? !commit : err_q;
    end

    assign scan_out  = shadow_q[CFG_BITS-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    logic [NUM_OUTS-1:0] mux_out;
    logic [NUM_OUTS-1:0] gated_out;

    for (genvar k = 0; k < NUM_OUTS; k++) begin : gen_mux
        cb_track_mux #(
            .ChannelWidth (CHANNEL_ONEWAY_WIDTH),
            .NumOuts      (NUM_OUTS),
            .Index        (k),
            .SelW         (SEL_W)
        ) u_mux (
            .tracks_0_i (tracks_0),
            .tracks_1_i (tracks_1),
            .sel_i      (active_q[k*SEL_W +: SEL_W]),
            .y_o        (mux_out[k])
        );
    end

    assign gated_out = valid_q ? mux_out : '0;

    if (REG_OUT != 0) begin : gen_reg_out
        logic [NUM_OUTS-1:0] out_q;
        always_ff @(posedge scan_clk or negedge scan_rst_n) begin
            if (!scan_rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= gated_out;
            end
        end
        assign out = out_q;
    end else begin : gen_comb_out
        assign out = gated_out;
    end

endmodule

// File: tb/tb_connection_block_cfg.sv
module tb_connection_block_cfg;

    logic       scan_clk = 1'b0;
    logic       scan_rst_n;
    logic [7:0] tracks_0;
    logic [7:0] tracks_1;
    logic       scan_in;
    logic       scan_en;
    logic       cfg_update;

    logic       scan_out,   cfg_valid,   cfg_err;
    logic [3:0] out;
    logic       scan_out_r, cfg_valid_r, cfg_err_r;
    logic [3:0] out_r;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference state of the committed configuration.
    logic [7:0] m_active = 8'h00;
    logic       m_valid  = 1'b0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_r_q[$];

    always #5 scan_clk = ~scan_clk;

    connection_block_cfg #(
        .CHANNEL_ONEWAY_WIDTH (8),
        .NUM_OUTS             (4),
        .REG_OUT              (0)
    ) dut (
        .scan_clk   (scan_clk),
        .scan_rst_n (scan_rst_n),
        .tracks_0   (tracks_0),
        .tracks_1   (tracks_1),
        .scan_in    (scan_in),
        .scan_en    (scan_en),
        .cfg_update (cfg_update),
        .scan_out   (scan_out),
        .out        (out),
        .cfg_valid  (cfg_valid),
        .cfg_err    (cfg_err)
    );

    connection_block_cfg #(
        .CHANNEL_ONEWAY_WIDTH (8),
        .NUM_OUTS             (4),
        .REG_OUT              (1)
    ) dut_r (
        .scan_clk   (scan_clk),
        .scan_rst_n (scan_rst_n),
        .tracks_0   (tracks_0),
        .tracks_1   (tracks_1),
        .scan_in    (scan_in),
        .scan_en    (scan_en),
        .cfg_update (cfg_update),
        .scan_out   (scan_out_r),
        .out        (out_r),
        .cfg_valid  (cfg_valid_r),
        .cfg_err    (cfg_err_r)
    );

    // out[k]: sel = cfg[2k+:2]; tap j = k + 4*sel[1]; sel[0] picks tracks_1.
    function automatic logic [3:0] model_out(input logic [7:0] act, input logic vld,
                                             input logic [7:0] t0, input logic [7:0] t1);
        logic [3:0] r;
        logic [1:0] s;
        int         j;
        r = 4'b0;
        for (int k = 0; k < 4; k++) begin
            s    = act[2*k +: 2];
            j    = k + 4 * int'(s[1]);
            r[k] = s[0] ? t1[j] : t0[j];
        end
        return vld ? r : 4'b0;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic shift_bit(input logic b, input logic upd);
        @(negedge scan_clk);
        scan_en    = 1'b1;
        scan_in    = b;
        cfg_update = upd;
        @(negedge scan_clk);
        scan_en    = 1'b0;
        cfg_update = 1'b0;
    endtask

    task automatic shift_word(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            shift_bit(bits[i], 1'b0);
        end
    endtask

    task automatic update_pulse();
        @(negedge scan_clk);
        scan_en    = 1'b0;
        cfg_update = 1'b1;
        @(negedge scan_clk);
        cfg_update = 1'b0;
    endtask

    // Drive tracks and queue the expected comb output (model-derived).
    task automatic drive_tracks(input logic [7:0] t0, input logic [7:0] t1);
        @(negedge scan_clk);
        tracks_0 = t0;
        tracks_1 = t1;
        exp_q.push_back(model_out(m_active, m_valid, t0, t1));
        #1;
    endtask

    // Drive tracks and queue a directed expected value.
    task automatic drive_tracks_exp(input logic [7:0] t0, input logic [7:0] t1,
                                    input logic [3:0] e);
        @(negedge scan_clk);
        tracks_0 = t0;
        tracks_1 = t1;
        exp_q.push_back(e);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] e;
        scan_rst_n = 1'b0;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        cfg_update = 1'b0;
        tracks_0   = 8'hFF;
        tracks_1   = 8'hFF;
        exp_q.push_back(4'b0000);
        #3;
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL reset_out: got %b want %b", out, e); end
        vec_cnt++; if (out_r !== 4'b0000) begin err_cnt++; $display("FAIL reset_out_r: got %b want 0000", out_r); end
        vec_cnt++; if (cfg_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", cfg_valid); end
        vec_cnt++; if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %b want 0", cfg_err); end
        vec_cnt++; if (scan_out !== 1'b0) begin err_cnt++; $display("FAIL reset_scan_out: got %b want 0", scan_out); end
        @(negedge scan_clk);
        scan_rst_n = 1'b1;
        drive_tracks(8'hFF, 8'hFF);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL post_reset_out: got %b want %b", out, e); end
    endtask

    task automatic test_load();
        logic [3:0] e;
        shift_word(16'h00E4, 8);
        vec_cnt++; if (scan_out !== 1'b1) begin err_cnt++; $display("FAIL load_scan_out: got %b want 1", scan_out); end
        vec_cnt++; if (cfg_valid !== 1'b0) begin err_cnt++; $display("FAIL load_valid_pre: got %b want 0", cfg_valid); end
        vec_cnt++; if (out !== 4'b0000) begin err_cnt++; $display("FAIL load_out_pre: got %b want 0000", out); end
        update_pulse();
        m_active = 8'hE4;
        m_valid  = 1'b1;
        vec_cnt++; if (cfg_valid !== 1'b1) begin err_cnt++; $display("FAIL load_valid: got %b want 1", cfg_valid); end
        vec_cnt++; if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL load_err: got %b want 0", cfg_err); end
        vec_cnt++; if (out !== 4'b1111) begin err_cnt++; $display("FAIL load_out_ff: got %b want 1111", out); end
        // Registered copy lags the commit by one cycle.
        vec_cnt++; if (out_r !== 4'b0000) begin err_cnt++; $display("FAIL load_out_r_lag: got %b want 0000", out_r); end
        @(negedge scan_clk);
        vec_cnt++; if (out_r !== 4'b1111) begin err_cnt++; $display("FAIL load_out_r: got %b want 1111", out_r); end
        // out0<-t0[0], out1<-t1[1], out2<-t0[6], out3<-t1[7]
        drive_tracks_exp(8'h41, 8'h00, 4'b0101);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL load_dir_t0: got %b want %b", out, e); end
        drive_tracks_exp(8'h00, 8'h82, 4'b1010);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL load_dir_t1: got %b want %b", out, e); end
        drive_tracks_exp(8'hBE, 8'h7D, 4'b0000);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL load_dir_inv: got %b want %b", out, e); end
        for (int i = 0; i < 6; i++) begin
            drive_tracks(8'($urandom), 8'($urandom));
            e = exp_q.pop_front();
            vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL load_rand%0d: got %b want %b", i, out, e); end
        end
    endtask

    task automatic test_short_load();
        logic [3:0] e;
        shift_word(16'h001B, 7);
        update_pulse();
        vec_cnt++; if (cfg_err !== 1'b1) begin err_cnt++; $display("FAIL short_err: got %b want 1", cfg_err); end
        vec_cnt++; if (cfg_valid !== 1'b1) begin err_cnt++; $display("FAIL short_valid: got %b want 1", cfg_valid); end
        drive_tracks(8'h41, 8'h82);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL short_active_kept: got %b want %b", out, e); end
        shift_word(16'h001B, 8);
        update_pulse();
        m_active = 8'h1B;
        vec_cnt++; if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL short_recover_err: got %b want 0", cfg_err); end
        // out0<-t1[4], out1<-t0[5], out2<-t1[2], out3<-t0[3]
        drive_tracks_exp(8'h28, 8'h00, 4'b1010);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL short_dir_t0: got %b want %b", out, e); end
        drive_tracks_exp(8'h00, 8'h14, 4'b0101);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL short_dir_t1: got %b want %b", out, e); end
    endtask

    task automatic test_over();
        logic [3:0] e;
        // 9 bits, first (MSB) is 1; shadow MSB is 0 beforehand.
        shift_word(16'h00D2, 8);
        vec_cnt++; if (scan_out !== 1'b1) begin err_cnt++; $display("FAIL over_scan_out: got %b want 1", scan_out); end
        shift_bit(1'b1, 1'b0);
        update_pulse();
        vec_cnt++; if (cfg_err !== 1'b1) begin err_cnt++; $display("FAIL over_err: got %b want 1", cfg_err); end
        drive_tracks(8'($urandom), 8'($urandom));
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL over_active_kept: got %b want %b", out, e); end
        shift_word(16'h00E4, 8);
        update_pulse();
        m_active = 8'hE4;
        vec_cnt++; if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL over_recover_err: got %b want 0", cfg_err); end
    endtask

    task automatic test_update_with_shift();
        logic [3:0]  e;
        logic [15:0] w;
        // Round A: rejected update on 8th shift, counter keeps going -> FULL.
        w = 16'h006C;
        shift_word(w >> 1, 7);
        shift_bit(w[0], 1'b1);
        vec_cnt++; if (cfg_err !== 1'b1) begin err_cnt++; $display("FAIL uws_a_err: got %b want 1", cfg_err); end
        drive_tracks(8'($urandom), 8'($urandom));
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL uws_a_kept: got %b want %b", out, e); end
        update_pulse();
        m_active = 8'h6C;
        vec_cnt++; if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL uws_a_commit_err: got %b want 0", cfg_err); end
        drive_tracks(8'($urandom), 8'($urandom));
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL uws_a_commit_out: got %b want %b", out, e); end
        // Round B: same, then a 9th shift -> OVER -> rejected.
        w = 16'h0093;
        shift_word(w >> 1, 7);
        shift_bit(w[0], 1'b1);
        vec_cnt++; if (cfg_err !== 1'b1) begin err_cnt++; $display("FAIL uws_b_err: got %b want 1", cfg_err); end
        shift_bit(1'b0, 1'b0);
        update_pulse();
        vec_cnt++; if (cfg_err !== 1'b1) begin err_cnt++; $display("FAIL uws_b_over_err: got %b want 1", cfg_err); end
        drive_tracks(8'($urandom), 8'($urandom));
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL uws_b_kept: got %b want %b", out, e); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        drive_tracks(8'hFF, 8'hFF);
        e = exp_q.pop_front();
        vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL rmid_pre_out: got %b want %b", out, e); end
        shift_word(16'h000A, 4);
        #2;
        scan_rst_n = 1'b0;
        #1;
        m_active = 8'h00;
        m_valid  = 1'b0;
        vec_cnt++; if (out !== 4'b0000) begin err_cnt++; $display("FAIL rmid_out: got %b want 0000", out); end
        vec_cnt++; if (out_r !== 4'b0000) begin err_cnt++; $display("FAIL rmid_out_r: got %b want 0000", out_r); end
        vec_cnt++; if (cfg_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid: got %b want 0", cfg_valid); end
        vec_cnt++; if (cfg_valid_r !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid_r: got %b want 0", cfg_valid_r); end
        @(negedge scan_clk);
        scan_rst_n = 1'b1;
        // Counter was cleared: an immediate update is rejected from IDLE.
        update_pulse();
        vec_cnt++; if (cfg_err !== 1'b1) begin err_cnt++; $display("FAIL rmid_idle_err: got %b want 1", cfg_err); end
        vec_cnt++; if (cfg_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_idle_valid: got %b want 0", cfg_valid); end
        // A fresh 8-bit load must now land exactly in FULL.
        shift_word(16'h00E4, 8);
        update_pulse();
        m_active = 8'hE4;
        m_valid  = 1'b1;
        vec_cnt++; if (cfg_err !== 1'b0) begin err_cnt++; $display("FAIL rmid_reload_err: got %b want 0", cfg_err); end
        vec_cnt++; if (cfg_valid !== 1'b1) begin err_cnt++; $display("FAIL rmid_reload_valid: got %b want 1", cfg_valid); end
    endtask

    task automatic test_reg_out();
        logic [7:0] pats [6];
        logic [3:0] prev_r, e, er;
        pats = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h41, 8'h40};
        @(negedge scan_clk);
        tracks_0 = 8'h00;
        tracks_1 = 8'h00;
        @(negedge scan_clk);
        prev_r = model_out(m_active, m_valid, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge scan_clk);
            tracks_0 = pats[i];
            exp_q.push_back(model_out(m_active, m_valid, pats[i], 8'h00));
            exp_r_q.push_back(model_out(m_active, m_valid, pats[i], 8'h00));
            #1;
            e = exp_q.pop_front();
            vec_cnt++; if (out !== e) begin err_cnt++; $display("FAIL reg_comb%0d: got %b want %b", i, out, e); end
            vec_cnt++; if (out_r !== prev_r) begin err_cnt++; $display("FAIL reg_hold%0d: got %b want %b", i, out_r, prev_r); end
            @(posedge scan_clk);
            #1;
            er = exp_r_q.pop_front();
            vec_cnt++; if (out_r !== er) begin err_cnt++; $display("FAIL reg_out%0d: got %b want %b", i, out_r, er); end
            prev_r = er;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_short_load();
        test_over();
        test_update_with_shift();
        test_reset_mid();
        test_reg_out();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vec_cnt);
        $fatal(1);
    end

endmodule

// File: doc/connection_block_cfg.md
Name: connection_block_cfg

Overview:
Parametrised connection block that drives NUM_OUTS CLB/IO input pins from a bidirectional routing channel, each through a configurable track mux. Configuration arrives over the scan chain into a shadow register and is committed to an active register only by an explicit update pulse after exactly CFG_BITS bits have been shifted. Outputs stay quiet until a valid configuration has been committed. This lets a partially shifted chain be reconfigured without glitching the fabric.

Parameters:
CHANNEL_ONEWAY_WIDTH, 8, tracks per direction; must be divisible by NUM_OUTS.
NUM_OUTS, 4, number of pin outputs driven.
REG_OUT, 0, 0 = combinational mux outputs; 1 = outputs registered on scan_clk.
SEL_W (derived), clog2(2*CHANNEL_ONEWAY_WIDTH/NUM_OUTS); the candidate count must be a power of two.
CFG_BITS (derived), NUM_OUTS*SEL_W.

Ports:
scan_clk  input  1  sole clock
scan_rst_n  input  1  reset; asynchronous, active-low
tracks_0  input  CHANNEL_ONEWAY_WIDTH  leftward tracks
tracks_1  input  CHANNEL_ONEWAY_WIDTH  rightward tracks
scan_in  input  1  serial configuration data
scan_en  input  1  shift enable
cfg_update  input  1  single-cycle commit request
scan_out  output  1  chain continuation, equal to shadow[CFG_BITS-1]
out  output  NUM_OUTS  pin drives
cfg_valid  output  1  an active configuration is loaded
cfg_err  output  1  sticky flag for a rejected update

Behaviour:
- Reset (asynchronous, scan_rst_n=0):
  - shadow, active, bit counter, out register all 0.
  - state=IDLE, cfg_valid=0, cfg_err=0, scan_out=0.
- Shift: when scan_en=1, shadow <= {shadow[CFG_BITS-2:0], scan_in}.
  - The first bit shifted lands in the MSB after CFG_BITS shifts.
- Bit counter: width clog2(CFG_BITS+2). Increments per shift and saturates at CFG_BITS+1.
- FSM states and transitions:
  - IDLE: counter=0. scan_en -> SHIFT.
  - SHIFT: 0<count<CFG_BITS. When count reaches CFG_BITS -> FULL.
  - FULL: count==CFG_BITS. Further shift -> OVER.
  - OVER: count>CFG_BITS. Stays in OVER until a cfg_update or reset.
- cfg_update with scan_en=0:
  - In FULL: active <= shadow, cfg_valid <= 1, cfg_err <= 0, counter cleared, -> IDLE. The new config takes effect the next cycle.
  - In IDLE, SHIFT or OVER: active unchanged, cfg_err <= 1, counter cleared, -> IDLE. The shadow is not cleared.
- cfg_update with scan_en=1 in the same cycle: the shift occurs, the update is rejected, cfg_err <= 1, and the counter continues counting.
- Mux for output k:
  - Select field is sel_k = active[k*SEL_W +: SEL_W].
  - Candidate m (m = 0 .. 2^SEL_W-1) is j = k + NUM_OUTS*(m>>1); m even -> tracks_0[j], m odd -> tracks_1[j].
  - Example at W=4, NUM_OUTS=2: out[0] candidates are {t0[0], t1[0], t0[2], t1[2]}.
- Output gating: out[k] = cfg_valid ? mux_k : 0.
  - REG_OUT=1 adds exactly one cycle of latency, covering both track changes and commit.
- Shifting never disturbs active or out.
- Reset mid-shift discards the partial load.

Decomposition:
- Shared package: FSM state encoding (IDLE/SHIFT/FULL/OVER), and clog2-style helper functions for SEL_W, CFG_BITS and counter width.
- One natural sub-module: cb_track_mux. It is a parametrised 2^SEL_W:1 mux plus the track-tap index mapping, instantiated NUM_OUTS times.
- The FSM, counter and shadow/active registers stay in the top module.

Test Plan:
- Defaults (SEL_W=2, CFG_BITS=8): after reset, drive tracks_0=8'hFF, tracks_1=8'hFF -> out=4'b0000, cfg_valid=0, scan_out=0.
- Load 8'b11_10_01_00 MSB-first (8 shifts), then pulse cfg_update -> cfg_valid=1 next cycle. Expected selections:
  - out[0] follows t0[0]
  - out[1] follows t1[1]
  - out[2] follows t0[6]
  - out[3] follows t1[7]
- Shift 7 bits, then pulse cfg_update -> cfg_err=1, active unchanged. Then a full 8-bit load plus update -> cfg_err=0.
- Shift 9 bits (OVER), then pulse cfg_update -> cfg_err=1. Also check scan_out equals the 1st shifted bit after 8 shifts.
- Assert cfg_update together with the 8th shift -> rejected, cfg_err=1. A 9th shift then takes the FSM to OVER.
- Mid-load of a second config, assert scan_rst_n=0 asynchronously -> out=0 immediately, cfg_valid=0.
- REG_OUT=1: toggle the selected track -> out toggles exactly one cycle later.
